it_core_param: RTL and testbench

//   Parametrised accumulator CPU core; successor to the fixed 8-bit/32-word control-unit + datapath pair.

---
 rtl/it_core_param.sv | 238 +++++++++++++++++++++++
 tb/tb_it_core_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/it_core_param.sv
// Parametrised accumulator CPU core with FSM control, datapath and an
// internal 2**ADDR_W x DATA_W program/data RAM.
//
// Ports:
//   Clock      rising-edge system clock
//   Reset      asynchronous active-low reset
//   Enter      INPUT strobe (level, edge-detected internally)
//   Input      data captured into A by INPUT
//   programEn  1 = program-load mode, execution suspended
//   Addrload   AddrIn <= AddrSel (program mode only)
//   PRload     RAM[AddrIn] <= ProgData (program mode only)
//   AddrSel    load address and RAMout debug read address
//   ProgData   program word to write
//   Halt       high while halted
//   Output     accumulator A
//   RAMout     RAM[AddrSel], combinational
//   AddrIn     program-load address register
//   Ovf        signed overflow of the last ADD/SUB
//   outState   FSM state code
module it_core_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Enter,
    input  logic [DATA_W-1:0] Input,
    input  logic              programEn,
    input  logic              Addrload,
    input  logic              PRload,
    input  logic [ADDR_W-1:0] AddrSel,
    input  logic [DATA_W-1:0] ProgData,
    output logic              Halt,
    output logic [DATA_W-1:0] Output,
    output logic [DATA_W-1:0] RAMout,
    output logic [ADDR_W-1:0] AddrIn,
    output logic              Ovf,
    output logic [3:0]        outState
);

    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_INWAIT = 4'd4,
        S_HALT   = 4'd5,
        S_PROG   = 4'd6
    } state_e;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_INPUT = 3'b100;
    localparam logic [2:0] OP_JZ    = 3'b101;
    localparam logic [2:0] OP_JPOS  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int MSB = DATA_W - 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] addr_in_q, addr_in_d;
    logic              ovf_q, ovf_d;
    logic              enter_q;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;

    logic [2:0]        opcode;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] m_rd;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic [DATA_W-1:0] neg_m;
    logic              ovf_add;
    logic              ovf_sub;
    logic              a_eq0;
    logic              a_pos;
    logic              enter_rise;
    logic              ir_unused;

    assign opcode  = ir_q[MSB -: 3];
    assign op_addr = ir_q[ADDR_W-1:0];
    // Bits between opcode and operand address carry no meaning.
    assign ir_unused = ^ir_q;

    assign m_rd  = mem_q[op_addr];
    assign sum   = a_q + m_rd;
    assign diff  = a_q - m_rd;
    assign neg_m = '0 - m_rd;

    // Overflow: operand signs agree but result sign differs.
    // SUB is treated as A + (-M).
    assign ovf_add = (a_q[MSB] == m_rd[MSB])
                   && (sum[MSB] != a_q[MSB]);
    assign ovf_sub = (a_q[MSB] == neg_m[MSB])
                   && (diff[MSB] != a_q[MSB]);

    assign a_eq0 = (a_q == '0);
    assign a_pos = ~a_q[MSB] & ~a_eq0;

    assign enter_rise = Enter & ~enter_q;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        addr_in_d = addr_in_q;
        ovf_d     = ovf_q;
        mem_we    = 1'b0;
        mem_wa    = addr_in_q;
        mem_wd    = ProgData;

        // Program mode preempts everything; work in flight is dropped.
        if (programEn && state_q != S_PROG) begin
            state_d = S_PROG;
        end else begin
            case (state_q)
                S_START: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    ir_d    = mem_q[pc_q];
                    pc_d    = pc_q + 1'b1;
                    state_d = S_DECODE;
                end
                S_DECODE: begin
                    if (opcode == OP_INPUT) begin
                        state_d = S_INWAIT;
                    end else if (opcode == OP_HALT) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (opcode)
                        OP_LOAD: a_d = m_rd;
                        OP_STORE: begin
                            mem_we = 1'b1;
                            mem_wa = op_addr;
                            mem_wd = a_q;
                        end
                        OP_ADD: begin
                            a_d   = sum;
                            ovf_d = ovf_add;
                        end
                        OP_SUB: begin
                            a_d   = diff;
                            ovf_d = ovf_sub;
                        end
                        OP_JZ: begin
                            if (a_eq0) pc_d = op_addr;
                        end
                        OP_JPOS: begin
                            if (a_pos) pc_d = op_addr;
                        end
                        default: ;
                    endcase
                end
                S_INWAIT: begin
                    if (enter_rise) begin
                        a_d     = Input;
                        state_d = S_FETCH;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                S_PROG: begin
                    // Write uses the pre-edge AddrIn; Addrload wins
                    // over the auto-increment.
                    if (PRload) begin
                        mem_we    = 1'b1;
                        mem_wa    = addr_in_q;
                        mem_wd    = ProgData;
                        addr_in_d = addr_in_q + 1'b1;
                    end
                    if (Addrload) begin
                        addr_in_d = AddrSel;
                    end
                    if (!programEn) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                        a_d     = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_START;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_START;
            a_q       <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            addr_in_q <= '0;
            ovf_q     <= 1'b0;
            enter_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            addr_in_q <= addr_in_d;
            ovf_q     <= ovf_d;
            enter_q   <= Enter;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign Halt     = (state_q == S_HALT);
    assign Output   = a_q;
    assign RAMout   = mem_q[AddrSel];
    assign AddrIn   = addr_in_q;
    assign Ovf      = ovf_q;
    assign outState = state_q;

endmodule

// File: tb/tb_it_core_param.sv
// Directed testbench for it_core_param: default 8/5 instance plus a
// 12/7 instance for width and PC-wrap coverage.
module tb_it_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, enter, prog_en, addr_ld, pr_ld;
    logic [7:0] din, pdata;
    logic [4:0] asel;
    logic       halt, ovf;
    logic [7:0] dout, ramout;
    logic [4:0] addr_in;
    logic [3:0] st;

    logic        b_rst_n, b_enter, b_prog_en, b_addr_ld, b_pr_ld;
    logic [11:0] b_din, b_pdata;
    logic [6:0]  b_asel;
    logic        b_halt, b_ovf;
    logic [11:0] b_dout, b_ramout;
    logic [6:0]  b_addr_in;
    logic [3:0]  b_st;

    it_core_param #(.DATA_W(8), .ADDR_W(5)) u_dut (
        .Clock(clk), .Reset(rst_n), .Enter(enter), .Input(din),
        .programEn(prog_en), .Addrload(addr_ld), .PRload(pr_ld),
        .AddrSel(asel), .ProgData(pdata), .Halt(halt),
        .Output(dout), .RAMout(ramout), .AddrIn(addr_in),
        .Ovf(ovf), .outState(st)
    );

    it_core_param #(.DATA_W(12), .ADDR_W(7)) u_dut_w (
        .Clock(clk), .Reset(b_rst_n), .Enter(b_enter), .Input(b_din),
        .programEn(b_prog_en), .Addrload(b_addr_ld), .PRload(b_pr_ld),
        .AddrSel(b_asel), .ProgData(b_pdata), .Halt(b_halt),
        .Output(b_dout), .RAMout(b_ramout), .AddrIn(b_addr_in),
        .Ovf(b_ovf), .outState(b_st)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] img [32];

    task automatic clr_img();
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
    endtask

    task automatic enter_prog();
        @(negedge clk);
        prog_en = 1'b1;
        @(negedge clk);
    endtask

    // Loads img[0..31] from address 0 using auto-increment.
    task automatic load_img();
        addr_ld = 1'b1;
        asel    = 5'd0;
        @(negedge clk);
        addr_ld = 1'b0;
        pr_ld   = 1'b1;
        for (int i = 0; i < 32; i++) begin
            pdata = img[i];
            @(negedge clk);
        end
        pr_ld = 1'b0;
    endtask

    task automatic run_img();
        enter_prog();
        load_img();
        prog_en = 1'b0;
    endtask

    initial begin
        int         cyc;
        int         nchg;
        logic [7:0] prev;
        logic [7:0] exp_seq [6];
        logic [3:0] exp_st [6];

        exp_seq = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        exp_st  = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd2, 4'd3};

        rst_n = 0; enter = 0; prog_en = 0; addr_ld = 0; pr_ld = 0;
        din = 0; pdata = 0; asel = 0;
        b_rst_n = 0; b_enter = 0; b_prog_en = 0; b_addr_ld = 0;
        b_pr_ld = 0; b_din = 0; b_pdata = 0; b_asel = 0;

        repeat (2) @(negedge clk);
        chk("rst_state", st, 4'd0);
        chk("rst_out", dout, 8'h00);
        chk("rst_halt", halt, 1'b0);
        chk("rst_addrin", addr_in, 5'd0);
        chk("rst_ovf", ovf, 1'b0);

        // Zero RAM, then restart from reset and watch the cycle.
        rst_n   = 1'b1;
        prog_en = 1'b1;
        @(negedge clk);
        clr_img();
        load_img();
        rst_n   = 1'b0;
        prog_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("start_state", st, 4'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("run_state", st, exp_st[i]);
        end
        chk("run_out", dout, 8'h00);
        chk("run_halt", halt, 1'b0);

        // Program-load addressing.
        enter_prog();
        addr_ld = 1'b1; asel = 5'd3;
        @(negedge clk);
        addr_ld = 1'b0; pr_ld = 1'b1; pdata = 8'h11;
        @(negedge clk);
        pdata = 8'h22;
        @(negedge clk);
        pdata = 8'h33;
        @(negedge clk);
        pr_ld = 1'b0;
        chk("addrin_inc", addr_in, 5'd6);
        asel = 5'd3; #1 chk("ram3", ramout, 8'h11);
        asel = 5'd4; #1 chk("ram4", ramout, 8'h22);
        asel = 5'd5; #1 chk("ram5", ramout, 8'h33);
        @(negedge clk);
        addr_ld = 1'b1; asel = 5'd9; pr_ld = 1'b1; pdata = 8'h44;
        @(negedge clk);
        addr_ld = 1'b0; pr_ld = 1'b0;
        chk("addrin_ld", addr_in, 5'd9);
        asel = 5'd6; #1 chk("ram_old_addr", ramout, 8'h44);
        asel = 5'd9; #1 chk("ram_new_addr", ramout, 8'h00);

        // Countdown: LOAD 10; SUB 11; JPOS 1; HALT.
        clr_img();
        img[0] = 8'h0A; img[1] = 8'h6B; img[2] = 8'hC1; img[3] = 8'hE0;
        img[10] = 8'h05; img[11] = 8'h01;
        run_img();
        cyc = 0; nchg = 0; prev = 8'h00;
        while (!halt && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (dout !== prev) begin
                if (nchg < 6) chk("count_a", dout, exp_seq[nchg]);
                nchg++;
                prev = dout;
            end
        end
        chk("halt_cycle", cyc, 36);
        chk("count_steps", nchg, 6);
        repeat (10) @(negedge clk);
        chk("halt_hold", halt, 1'b1);
        chk("halt_state", st, 4'd5);
        chk("halt_out", dout, 8'h00);

        // INPUT with Enter edge detection.
        clr_img();
        img[0] = 8'h80; img[1] = 8'h80; img[2] = 8'hE0;
        run_img();
        repeat (20) @(negedge clk);
        chk("inwait", st, 4'd4);
        din = 8'h5A; enter = 1'b1;
        @(negedge clk);
        chk("in_capture", dout, 8'h5A);
        din = 8'h33;
        repeat (10) @(negedge clk);
        chk("held_wait", st, 4'd4);
        chk("held_nocap", dout, 8'h5A);
        enter = 1'b0;
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        chk("in_recap", dout, 8'h33);
        enter = 1'b0;
        repeat (5) @(negedge clk);
        chk("in_halt", halt, 1'b1);

        // Signed overflow.
        clr_img();
        img[0] = 8'h14; img[1] = 8'h55; img[2] = 8'h75;
        img[3] = 8'h56; img[4] = 8'hE0;
        img[20] = 8'h7F; img[21] = 8'h01; img[22] = 8'h00;
        run_img();
        repeat (4) @(negedge clk);
        chk("ovf_load_a", dout, 8'h7F);
        chk("ovf_load", ovf, 1'b0);
        repeat (3) @(negedge clk);
        chk("add_a", dout, 8'h80);
        chk("add_ovf", ovf, 1'b1);
        repeat (3) @(negedge clk);
        chk("sub_a", dout, 8'h7F);
        chk("sub_ovf", ovf, 1'b1);
        repeat (3) @(negedge clk);
        chk("add0_a", dout, 8'h7F);
        chk("add0_ovf", ovf, 1'b0);

        // Reset during EXEC of STORE.
        clr_img();
        img[0] = 8'h14; img[1] = 8'h39; img[2] = 8'hE0;
        img[20] = 8'h7F; img[25] = 8'h66;
        run_img();
        repeat (6) @(negedge clk);
        chk("store_exec", st, 4'd3);
        chk("store_pre_a", dout, 8'h7F);
        rst_n   = 1'b0;
        prog_en = 1'b1;
        #1;
        chk("mid_rst_state", st, 4'd0);
        chk("mid_rst_out", dout, 8'h00);
        chk("mid_rst_halt", halt, 1'b0);
        @(negedge clk);
        asel = 5'd25;
        #1 chk("store_blocked", ramout, 8'h66);
        rst_n = 1'b1;

        // Wide instance: INPUT at 0, LOAD 0 everywhere else.
        @(negedge clk);
        b_rst_n = 1'b1; b_prog_en = 1'b1;
        @(negedge clk);
        b_addr_ld = 1'b1; b_asel = 7'd0;
        @(negedge clk);
        b_addr_ld = 1'b0; b_pr_ld = 1'b1;
        for (int i = 0; i < 128; i++) begin
            b_pdata = (i == 0) ? 12'h800 : 12'h000;
            @(negedge clk);
        end
        b_pr_ld = 1'b0; b_prog_en = 1'b0;
        repeat (5) @(negedge clk);
        chk("w_inwait", b_st, 4'd4);
        b_din = 12'hABC; b_enter = 1'b1;
        @(negedge clk);
        chk("w_capture", b_dout, 12'hABC);
        cyc = 0;
        while (b_st !== 4'd4 && cyc < 600) begin
            @(negedge clk);
            cyc++;
        end
        chk("w_pc_wrap_cyc", cyc, 383);
        chk("w_pc_wrap_a", b_dout, 12'h800);
        chk("w_ovf", b_ovf, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
